correlator_scheduler: RTL and testbench

//   Time-shares a single correlator datapath among three 10-bit operands a, b, c.

---
 rtl/correlator_scheduler.sv | 116 +++++++++++
 tb/tb_correlator_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/correlator_scheduler.sv
// Time-shares one bit-permuting XOR correlator across the ab, ac and bc pairs of a latched operand triple.
// One enabled pair per cycle; results are held in DONE until out_ready, and in_ready is high only in IDLE.
module correlator_scheduler #(
  parameter logic [2:0] PAIR_MASK = 3'b111,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       a,
  input  logic [9:0]       b,
  input  logic [9:0]       c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       ab_correlation,
  output logic [9:0]       ac_correlation,
  output logic [9:0]       bc_correlation,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  typedef enum logic [2:0] {IDLE, S_AB, S_AC, S_BC, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic [9:0] a_r, b_r, c_r;
  logic [9:0] sel_x, sel_y, corr_out;

  // x is bit-permuted, y is rotated; the two are combined with a plain XOR.
  function automatic logic [9:0] corr(input logic [9:0] x, input logic [9:0] y);
    corr = {x[9], x[7], x[5], x[3], x[1], x[0], x[2], x[4], x[6], x[8]}
         ^ {y[4:3], y[9:5], y[2:0]};
  endfunction

  always_comb begin
    sel_x = a_r;
    sel_y = b_r;
    case (state)
      S_AC:    begin sel_x = a_r; sel_y = c_r; end
      S_BC:    begin sel_x = b_r; sel_y = c_r; end
      default: begin sel_x = a_r; sel_y = b_r; end
    endcase
  end

  assign corr_out = corr(sel_x, sel_y);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          if      (PAIR_MASK[0]) state_nxt = S_AB;
          else if (PAIR_MASK[1]) state_nxt = S_AC;
          else if (PAIR_MASK[2]) state_nxt = S_BC;
          else                   state_nxt = DONE;
        end
      end
      S_AB: begin
        if      (PAIR_MASK[1]) state_nxt = S_AC;
        else if (PAIR_MASK[2]) state_nxt = S_BC;
        else                   state_nxt = DONE;
      end
      S_AC: begin
        if (PAIR_MASK[2]) state_nxt = S_BC;
        else              state_nxt = DONE;
      end
      S_BC: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      a_r            <= '0;
      b_r            <= '0;
      c_r            <= '0;
      ab_correlation <= '0;
      ac_correlation <= '0;
      bc_correlation <= '0;
      job_count      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // Clearing on accept makes skipped pairs read 0.
          if (in_valid) begin
            a_r            <= a;
            b_r            <= b;
            c_r            <= c;
            ab_correlation <= '0;
            ac_correlation <= '0;
            bc_correlation <= '0;
          end
        end
        S_AB: ab_correlation <= corr_out;
        S_AC: ac_correlation <= corr_out;
        S_BC: bc_correlation <= corr_out;
        DONE: if (out_ready) job_count <= job_count + CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_correlator_scheduler.sv
// Randomized self-checking bench: a default-mask instance plus a PAIR_MASK=3'b010 instance checked against a table-driven model.
module tb_correlator_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [9:0] a, b, c, ab, ac, bc;
  logic [7:0] job_count;

  logic       in_valid_m, in_ready_m, out_valid_m, out_ready_m, busy_m;
  logic [9:0] a_m, b_m, c_m, ab_m, ac_m, bc_m;
  logic [7:0] job_count_m;

  int n_checks = 0;
  int n_errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  correlator_scheduler dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .ab_correlation(ab), .ac_correlation(ac), .bc_correlation(bc),
    .busy(busy), .job_count(job_count)
  );

  correlator_scheduler #(.PAIR_MASK(3'b010), .CNT_W(8)) dut_m (
    .clk(clk), .reset(reset), .in_valid(in_valid_m), .in_ready(in_ready_m),
    .a(a_m), .b(b_m), .c(c_m), .out_valid(out_valid_m), .out_ready(out_ready_m),
    .ab_correlation(ab_m), .ac_correlation(ac_m), .bc_correlation(bc_m),
    .busy(busy_m), .job_count(job_count_m)
  );

  // Source bit for each output bit, listed from output bit 9 down to bit 0.
  localparam int XS[10] = '{9, 7, 5, 3, 1, 0, 2, 4, 6, 8};
  localparam int YS[10] = '{4, 3, 9, 8, 7, 6, 5, 2, 1, 0};

  function automatic logic [9:0] corr_ref(input logic [9:0] x, input logic [9:0] y);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[9-i] = x[XS[i]] ^ y[YS[i]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job on the default instance: accept, measure latency, hold in DONE, then hand off.
  task automatic do_job(input logic [9:0] ja, input logic [9:0] jb, input logic [9:0] jc,
                        input int hold);
    int lat;
    logic [9:0] eab, eac, ebc;
    eab = corr_ref(ja, jb);
    eac = corr_ref(ja, jc);
    ebc = corr_ref(jb, jc);
    lat = 0;
    while (!in_ready && lat < 20) begin tick(); lat++; end
    check("in_ready_before_accept", in_ready, 1);
    a = ja; b = jb; c = jc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 10'($urandom); b = 10'($urandom); c = 10'($urandom);
    check("busy_after_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    check("latency", lat, 3);
    check("ab", ab, eab);
    check("ac", ac, eac);
    check("bc", bc, ebc);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = 10'($urandom); b = 10'($urandom); c = 10'($urandom);
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_ab", ab, eab);
      check("hold_ac", ac, eac);
      check("hold_bc", bc, ebc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    check("job_count", job_count, exp_count);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_hold_ab", ab, eab);
  endtask

  initial begin
    int lat;
    logic [9:0] ra, rb, rc;
    reset = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0; c = 0;
    in_valid_m = 0; out_ready_m = 0; a_m = 0; b_m = 0; c_m = 0;
    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_job_count", job_count, 0);
    check("rst_results", {ab, ac, bc}, 0);

    do_job(10'h3FF, 10'h000, 10'h000, 0);
    check("t1_ab", ab, 10'h3FF);
    check("t1_ac", ac, 10'h3FF);
    check("t1_bc", bc, 10'h000);
    do_job(10'h000, 10'h020, 10'h000, 0);
    check("t2_ab_020", ab, 10'h008);
    do_job(10'h000, 10'h018, 10'h000, 0);
    check("t2_ab_018", ab, 10'h300);
    do_job(10'h001, 10'h000, 10'h000, 0);
    check("t2_ab_001", ab, 10'h010);
    do_job(10'($urandom), 10'($urandom), 10'($urandom), 5);
    for (int j = 0; j < 40; j++)
      do_job(10'($urandom), 10'($urandom), 10'($urandom), $urandom_range(0, 3));

    // Masked instance: only the ac pair runs.
    for (int j = 0; j < 20; j++) begin
      if (j == 0) begin ra = 10'h000; rb = 10'h3FF; rc = 10'h3FF; end
      else begin ra = 10'($urandom); rb = 10'($urandom); rc = 10'($urandom); end
      a_m = ra; b_m = rb; c_m = rc; in_valid_m = 1'b1;
      tick();
      in_valid_m = 1'b0;
      a_m = 10'($urandom);
      lat = 0;
      while (!out_valid_m && lat < 20) begin tick(); lat++; end
      check("m_latency", lat, 1);
      check("m_ab", ab_m, 0);
      check("m_ac", ac_m, corr_ref(ra, rc));
      check("m_bc", bc_m, 0);
      out_ready_m = 1'b1;
      tick();
      out_ready_m = 1'b0;
      check("m_job_count", job_count_m, j + 1);
    end

    // Abort a job in S_AC with reset.
    a = 10'($urandom); b = 10'($urandom); c = 10'($urandom); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 0;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_results", {ab, ac, bc}, 0);
    check("abort_job_count", job_count, 0);

    for (int i = 0; i <= 1022; i++) begin
      logic [9:0] ia;
      ia = 10'(i);
      do_job(ia, ~ia, 10'((ia << 4) + (ia >> 4)), (i % 97 == 0) ? 2 : 0);
    end
    check("final_job_count", job_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
